ats21_alarm_events: RTL and testbench

Event capture stage directly downstream of the ATS21 timer core. Samples the core's 24-bit alarm `data` bus, where each alarm asserts its bit for two cycles when it fires. Converts each rising edge into a queued event record (alarm id, optional timestamp) and presents records to a host consumer through a valid/ready FIFO interface. Records lost events in a saturating drop counter and a sticky overflow flag.

---
 rtl/ats21_alarm_events.sv | 142 ++++++++++++++
 tb/tb_ats21_alarm_events.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ats21_alarm_events.sv
// rtl/ats21_alarm_events.sv - ATS21 alarm rising-edge capture into a valid/ready event FIFO
//
// Ports:
//   clk         single clock for all logic
//   reset       asynchronous active-high reset, clears all state
//   alarm_data  alarm finished bits from the ATS21 timer core
//   evt_ready   consumer accepts the head record
//   clr_ovf     single-cycle pulse clearing overflow and drop_count
//   evt_valid   event FIFO non-empty
//   evt_id      alarm index of the head record
//   evt_ts      timestamp of the head record (0 unless ATS21_EVT_TIMESTAMP_EN)
//   pending     alarms detected but not yet queued
//   overflow    sticky lost-event flag
//   drop_count  saturating lost-event count
//   irq         equal to evt_valid
//
// Optional feature macro: ATS21_EVT_TIMESTAMP_EN adds a free-running
// timestamp counter and per-record timestamp storage.

module ats21_alarm_events #(
   parameter int NUM_ALARMS = 24,
   parameter int FIFO_DEPTH = 8,
   parameter int TS_WIDTH   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_ALARMS-1:0]         alarm_data,
   input  logic                          evt_ready,
   input  logic                          clr_ovf,
   output logic                          evt_valid,
   output logic [$clog2(NUM_ALARMS)-1:0] evt_id,
   output logic [TS_WIDTH-1:0]           evt_ts,
   output logic [NUM_ALARMS-1:0]         pending,
   output logic                          overflow,
   output logic [7:0]                    drop_count,
   output logic                          irq
);

   localparam int ID_W  = $clog2(NUM_ALARMS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int PC_W  = $clog2(NUM_ALARMS + 1);

   logic [NUM_ALARMS-1:0] prev_q;
   logic [NUM_ALARMS-1:0] rise;
   logic [NUM_ALARMS-1:0] grant_mask;
   logic [NUM_ALARMS-1:0] drop_vec;
   logic [ID_W-1:0]       sel_idx;
   logic [ID_W-1:0]       fifo_id [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  push;
   logic                  pop;
   logic [PC_W-1:0]       drop_num;
   logic [7:0]            drop_base;
   logic [8:0]            drop_sum;

   always_comb begin
      rise = alarm_data & ~prev_q;

      // Descending scan so the lowest set index wins.
      sel_idx = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (pending[i]) sel_idx = ID_W'(i);
      end

      // Eligibility uses the count before any pop this cycle: no pass-through when full.
      push = (|pending) && (count < CNT_W'(FIFO_DEPTH));

      grant_mask = '0;
      if (push) grant_mask[sel_idx] = 1'b1;

      // A re-rise of an alarm that is still waiting coalesces and is counted as lost,
      // unless that alarm is the one being queued this very cycle.
      drop_vec = rise & pending & ~grant_mask;

      drop_num = '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         drop_num = drop_num + PC_W'(drop_vec[i]);
      end

      // A clear coinciding with a drop restarts the count from the new losses.
      drop_base = clr_ovf ? 8'd0 : drop_count;
      drop_sum  = {1'b0, drop_base} + 9'(drop_num);
   end

   assign evt_valid = (count != '0);
   assign irq       = evt_valid;
   assign pop       = evt_valid & evt_ready;
   assign evt_id    = evt_valid ? fifo_id[rd_ptr] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q     <= '0;
         pending    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= 8'd0;
      end else begin
         prev_q  <= alarm_data;
         pending <= (pending & ~grant_mask) | rise;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
         if (|drop_vec) begin
            overflow   <= 1'b1;
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
         end else if (clr_ovf) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
         end
      end
   end

   // Record storage needs no reset: entries are only visible while counted as valid.
   always_ff @(posedge clk) begin
      if (push) fifo_id[wr_ptr] <= sel_idx;
   end

`ifdef ATS21_EVT_TIMESTAMP_EN
   logic [TS_WIDTH-1:0] ts_cnt;
   logic [TS_WIDTH-1:0] fifo_ts [FIFO_DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ts_cnt <= '0;
      else       ts_cnt <= ts_cnt + 1'b1;
   end

   // Captures the counter value present at the push edge, before its increment.
   always_ff @(posedge clk) begin
      if (push) fifo_ts[wr_ptr] <= ts_cnt;
   end

   assign evt_ts = evt_valid ? fifo_ts[rd_ptr] : '0;
`else
   assign evt_ts = '0;
`endif

endmodule

// File: tb/tb_ats21_alarm_events.sv
// tb/tb_ats21_alarm_events.sv - directed self-checking bench for ats21_alarm_events

module tb_ats21_alarm_events;

   logic        clk;
   logic        reset;
   logic [23:0] alarm_data;
   logic        evt_ready;
   logic        clr_ovf;
   logic        evt_valid;
   logic [4:0]  evt_id;
   logic [15:0] evt_ts;
   logic [23:0] pending;
   logic        overflow;
   logic [7:0]  drop_count;
   logic        irq;

   int checks = 0;
   int errors = 0;

   ats21_alarm_events dut (
      .clk        (clk),
      .reset      (reset),
      .alarm_data (alarm_data),
      .evt_ready  (evt_ready),
      .clr_ovf    (clr_ovf),
      .evt_valid  (evt_valid),
      .evt_id     (evt_id),
      .evt_ts     (evt_ts),
      .pending    (pending),
      .overflow   (overflow),
      .drop_count (drop_count),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input int id);
      alarm_data = 24'd1 << id;
      step(2);
      alarm_data = '0;
      step(1);
   endtask

   task automatic fill8(input int base);
      for (int k = 0; k < 8; k++) pulse(base + k);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, evt_valid, 0);
      chk({tag, "_id"}, evt_id, 0);
      chk({tag, "_ts"}, evt_ts, 0);
      chk({tag, "_pending"}, pending, 0);
      chk({tag, "_ovf"}, overflow, 0);
      chk({tag, "_drop"}, drop_count, 0);
      chk({tag, "_irq"}, irq, 0);
   endtask

   int ids [9] = '{7, 1, 22, 3, 9, 0, 15, 11, 4};
   int n_rec;
   int n_id2;

   initial begin
      reset      = 1'b1;
      alarm_data = '0;
      evt_ready  = 1'b0;
      clr_ovf    = 1'b0;
      step(2);
      chk_reset_vals("rst");
      reset = 1'b0;

      // Single 2-cycle pulse on bit 5 sampled at edge 10 (edge 0 is first after release).
      step(10);
      alarm_data = 24'd1 << 5;
      step(1);
      chk("t1_pend_e10", pending, 32'h20);
      chk("t1_valid_e10", evt_valid, 0);
      step(1);
      chk("t1_valid_e11", evt_valid, 1);
      chk("t1_id_e11", evt_id, 5);
      chk("t1_pend_e11", pending, 0);
`ifdef ATS21_EVT_TIMESTAMP_EN
      chk("t1_ts_e11", evt_ts, 11);
`endif
      alarm_data = '0;
      step(1);
      chk("t1_irq_hold", irq, 1);
      evt_ready = 1'b1;
      step(1);
      chk("t1_popped", evt_valid, 0);
      step(3);
      chk("t1_no_second", evt_valid, 0);

      // Simultaneous rises on 3, 0, 17 drain in ascending index.
      alarm_data = 24'h020009;
      step(1);
      chk("t2_pend_N", pending, 32'h020009);
      chk("t2_valid_N", evt_valid, 0);
      step(1);
      alarm_data = '0;
      chk("t2_id_N1", evt_id, 0);
      step(1);
      chk("t2_id_N2", evt_id, 3);
      step(1);
      chk("t2_id_N3", evt_id, 17);
      chk("t2_valid_N3", evt_valid, 1);
      step(1);
      chk("t2_empty", evt_valid, 0);
      chk("t2_drop", drop_count, 0);

      // Nine alarms with the consumer stalled: eight queue, one stays pending.
      evt_ready = 1'b0;
      for (int k = 0; k < 9; k++) pulse(ids[k]);
      chk("t3_valid_full", evt_valid, 1);
      chk("t3_pend_ninth", pending, 32'h10);
      chk("t3_drop", drop_count, 0);
      evt_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         chk($sformatf("t3_drain_valid%0d", k), evt_valid, 1);
         chk($sformatf("t3_drain_id%0d", k), evt_id, ids[k]);
         step(1);
      end
      chk("t3_drained", evt_valid, 0);
      chk("t3_pend_clear", pending, 0);

      // Full FIFO with bit 2 pending, bit 2 re-pulses -> one coalesced drop.
      evt_ready = 1'b0;
      fill8(10);
      pulse(2);
      chk("t4_pend2", pending, 32'h4);
      chk("t4_ovf_pre", overflow, 0);
      pulse(2);
      chk("t4_drop", drop_count, 1);
      chk("t4_ovf", overflow, 1);
      chk("t4_pend2_held", pending, 32'h4);
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      chk("t4_clr_drop", drop_count, 0);
      chk("t4_clr_ovf", overflow, 0);
      evt_ready = 1'b1;
      n_rec = 0;
      n_id2 = 0;
      for (int k = 0; k < 12; k++) begin
         if (evt_valid) begin
            n_rec++;
            if (evt_id == 5'd2) n_id2++;
         end
         step(1);
      end
      chk("t4_records", n_rec, 9);
      chk("t4_id2_once", n_id2, 1);
      evt_ready = 1'b0;

      // Drop counter saturation.
      fill8(10);
      pulse(2);
      for (int i = 1; i <= 300; i++) begin
         alarm_data = 24'h4;
         step(1);
         alarm_data = '0;
         step(1);
         if (i == 254) chk("t5_drop_254", drop_count, 254);
      end
      chk("t5_drop_sat", drop_count, 255);
      chk("t5_ovf", overflow, 1);

      // Clear and drop in the same cycle: drop wins.
      alarm_data = 24'h4;
      clr_ovf    = 1'b1;
      step(1);
      alarm_data = '0;
      clr_ovf    = 1'b0;
      chk("t5_clr_drop_cnt", drop_count, 1);
      chk("t5_clr_drop_ovf", overflow, 1);
      step(1);

      // Asynchronous reset mid-operation, alarm 6 held high across release.
      chk("t6_pre_valid", evt_valid, 1);
      chk("t6_pre_pend", pending, 32'h4);
      #2;
      reset      = 1'b1;
      alarm_data = 24'd1 << 6;
      #1;
      chk_reset_vals("t6_async");
      step(1);
      reset = 1'b0;
      step(1);
      chk("t6_rise_after_rel", pending, 32'h40);
      chk("t6_valid_e0", evt_valid, 0);
      step(1);
      chk("t6_valid_e1", evt_valid, 1);
      chk("t6_id_e1", evt_id, 6);
`ifdef ATS21_EVT_TIMESTAMP_EN
      chk("t6_ts_e1", evt_ts, 1);
`endif
      alarm_data = '0;
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
